mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single 16-bit synchronous memory port among three requesters.
- Port 0 is instruction fetch (read-only use), port 1 is the stack spill/fill unit, port 2 is the debug/program loader.
- Runs exactly one memory transaction at a time, using a req/ack handshake per port.
- Sits between the cpu core, the stack spill unit, the loader and the block RAM.

Parameters:
- ADDR_W, 16, width of the word address on every port and on the memory side.
- DATA_W, 16, data word width.
- READ_LAT, 1, memory read latency in cycles from the mem_en cycle to mem_rdata valid (legal 1..3).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req  in  3  per-port request; held high until the matching ack.
- we  in  3  per-port write enable; 1=write, 0=read; stable while req is high.
- addr  in  3*ADDR_W  per-port address, flattened; port n at [n*ADDR_W +: ADDR_W].
- wdata  in  3*DATA_W  per-port write data, flattened the same way.
- ack  out  3  one-cycle completion pulse, one-hot or zero.
- rdata  out  DATA_W  read data; valid in the ack cycle of a read.
- grant  out  3  one-hot owner of the current transaction; 0 when idle.
- busy  out  1  high whenever state != IDLE.
- mem_en  out  1  memory access strobe, exactly one cycle per transaction.
- mem_we  out  1  memory write strobe, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (synchronous, rst_n=0 at a clock edge):
  - state=IDLE; ack, grant, busy, mem_en, mem_we = 0; mem_addr, mem_wdata, rdata = 0.
  - Round-robin pointer = 0.
  - Applies from any state; an in-flight transaction is abandoned with no ack.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req bit is set, select a winner, then register grant, mem_addr, mem_we, mem_wdata from the winner's inputs and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - mem_en=1 for this single cycle.
  - If write: go to ACK.
  - If read: load the latency counter with READ_LAT-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture mem_rdata into rdata and go to ACK.
- ACK:
  - ack[grant]=1 for this single cycle; rdata holds.
  - Next cycle: grant=0 and state=IDLE.
  - Arbitration restarts in IDLE; there is no back-to-back grant from ACK.
- Latency, from the cycle req is sampled in IDLE to the ack cycle:
  - write: 2 cycles.
  - read: 2+READ_LAT cycles (3 with the default).
- A req bit sampled in IDLE is committed. Deasserting req mid-transaction does not cancel the transaction; the ack still pulses.
- A requester must not reassert req in its ack cycle expecting a new transaction. New requests are sampled only in IDLE.
- Requests arriving while busy wait; nothing is lost because req is level-held.
- mem_addr and mem_wdata hold their last values when idle; mem_we is cleared in ACK.
- rdata is updated only on read completion; writes leave it unchanged.
- Simultaneous requests resolve per the arbitration policy below.

Optional Feature:
- Macro: MEMARB_ROUND_ROBIN_EN.
- Defined — rotating priority:
  - Search starts at the pointer and proceeds pointer, pointer+1, pointer+2 (mod 3).
  - On each grant, pointer = winner+1 mod 3.
  - No starvation: any held req is granted within 3 transactions.
- Undefined — fixed priority port0 > port1 > port2:
  - The pointer register is not built.
  - Port 2 may starve if port 0 is continuously requesting.

Test Plan:
- Single read: mem[0x0010]=0x8005, port0 req=1/we=0/addr=0x0010 sampled cycle 0 → mem_en cycle 1 with mem_addr=0x0010, ack=3'b001 in cycle 3, rdata=0x8005, busy low in cycle 4.
- Write then read: port1 writes 0xBEEF to 0x0200 (ack=3'b010 in cycle 2), then port2 reads 0x0200 → ack=3'b100, rdata=0xBEEF; exactly one mem_en per transaction.
- Simultaneous requests: all three req high from reset release, all reads.
  - With MEMARB_ROUND_ROBIN_EN: grant order 0, 1, 2, then 0 again.
  - Without: port 0 is granted every transaction while held; port 2 is never granted.
- Request withdrawal: port1 read, req dropped in the ISSUE cycle → transaction completes and ack[1] still pulses; no second transaction starts.
- Reset mid-read: READ_LAT=3, rst_n=0 during WAIT → next cycle all outputs 0, state IDLE, no ack; after reset release a pending port0 req completes normally.
- Latency parameter: READ_LAT=2 → read ack exactly 4 cycles after sampling; rdata equals the mem_rdata presented 2 cycles after mem_en.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three requester ports and the block-RAM port of mem_port_arbiter.
// The arbiter side uses the slave modport; requesters/memory model use master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // Handshake: req[n] is level-held (with we/addr/wdata stable) until ack[n]
  // pulses for exactly one cycle; ack completes exactly one transaction.
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          ack;
  logic [DATA_W-1:0]   rdata;
  logic [2:0]          grant;
  logic                busy;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  ack, rdata, grant, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output ack, rdata, grant, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-port arbiter for the CPU's single synchronous memory port; one transaction at a time.
// Define MEMARB_ROUND_ROBIN_EN for rotating priority; default is fixed priority port0 > port1 > port2.
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [2:0]          grant_q, grant_n;
  logic [2:0]          ack_q, ack_n;
  logic                busy_q, busy_n;
  logic                en_q, en_n;
  logic                we_q, we_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;
  logic [DATA_W-1:0]   rdata_q, rdata_n;
  logic [1:0]          cnt_q, cnt_n;

  logic [ADDR_W-1:0]   port_addr  [3];
  logic [DATA_W-1:0]   port_wdata [3];
  logic [1:0]          win_idx;
  logic [2:0]          win_oh;

  for (genvar g = 0; g < 3; g++) begin : g_unpack
    assign port_addr[g]  = bus.addr[g*ADDR_W +: ADDR_W];
    assign port_wdata[g] = bus.wdata[g*DATA_W +: DATA_W];
  end

`ifdef MEMARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_n;

  // Search order starts at the pointer: ptr, ptr+1, ptr+2 (mod 3).
  always_comb begin
    win_idx = 2'd0;
    case (ptr_q)
      2'd1: begin
        if (bus.req[1])      win_idx = 2'd1;
        else if (bus.req[2]) win_idx = 2'd2;
        else                 win_idx = 2'd0;
      end
      2'd2: begin
        if (bus.req[2])      win_idx = 2'd2;
        else if (bus.req[0]) win_idx = 2'd0;
        else                 win_idx = 2'd1;
      end
      default: begin
        if (bus.req[0])      win_idx = 2'd0;
        else if (bus.req[1]) win_idx = 2'd1;
        else                 win_idx = 2'd2;
      end
    endcase
  end

  always_comb begin
    ptr_n = ptr_q;
    if (state == IDLE && (|bus.req)) begin
      ptr_n = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= 2'd0;
    else        ptr_q <= ptr_n;
  end
`else
  always_comb begin
    win_idx = 2'd0;
    if (bus.req[0])      win_idx = 2'd0;
    else if (bus.req[1]) win_idx = 2'd1;
    else                 win_idx = 2'd2;
  end
`endif

  assign win_oh = 3'b001 << win_idx;

  // Every output is a flop; this block computes the value each takes next cycle.
  always_comb begin
    state_n = state;
    grant_n = grant_q;
    ack_n   = 3'b000;
    en_n    = 1'b0;
    we_n    = we_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = rdata_q;
    cnt_n   = cnt_q;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_n = ISSUE;
          grant_n = win_oh;
          en_n    = 1'b1;
          we_n    = bus.we[win_idx];
          addr_n  = port_addr[win_idx];
          wdata_n = port_wdata[win_idx];
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_n = ACK;
          ack_n   = grant_q;
          we_n    = 1'b0;
        end else begin
          state_n = WAIT;
          cnt_n   = 2'(READ_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_n = ACK;
          ack_n   = grant_q;
          rdata_n = bus.mem_rdata;
          we_n    = 1'b0;
        end else begin
          cnt_n = cnt_q - 2'd1;
        end
      end
      ACK: begin
        state_n = IDLE;
        grant_n = 3'b000;
      end
      default: begin
        state_n = IDLE;
        grant_n = 3'b000;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= 3'b000;
      ack_q   <= 3'b000;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      ack_q   <= ack_n;
      busy_q  <= busy_n;
      en_q    <= en_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      rdata_q <= rdata_n;
      cnt_q   <= cnt_n;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: u0 (READ_LAT=1) with a RAM model, u2/u3 (READ_LAT=2/3)
// with a cycle-stamped read bus so the capture cycle is visible in rdata.
module tb_mem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b0 ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b2 ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b3 ();
  logic [1:0] st0, st2, st3;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave), .dbg_state(st0));
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave), .dbg_state(st2));
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3.slave), .dbg_state(st3));

  // ---------------- memory models ----------------
  logic [15:0]  mem [256];
  logic [255:0] written = '0;
  logic [15:0]  rd0 = '0;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    case (a)
      16'h0010: return 16'h8005;
      16'h0040: return 16'h1234;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  always @(posedge clk) begin
    if (b0.mem_en) begin
      if (b0.mem_we) begin
        mem[b0.mem_addr[7:0]]     <= b0.mem_wdata;
        written[b0.mem_addr[7:0]] <= 1'b1;
      end else begin
        rd0 <= written[b0.mem_addr[7:0]] ? mem[b0.mem_addr[7:0]] : init_val(b0.mem_addr);
      end
    end
  end
  assign b0.mem_rdata = rd0;

  logic [15:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;
  assign b2.mem_rdata = cyc ^ 16'hA5A5;
  assign b3.mem_rdata = cyc ^ 16'hA5A5;

  int en0_cnt  = 0;
  int ack3_cnt = 0;
  always @(posedge clk) begin
    if (b0.mem_en) en0_cnt <= en0_cnt + 1;
    if (b3.ack != 3'b000) ack3_cnt <= ack3_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [2:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port0(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
    b0.we[p]          = w;
    b0.addr[p*16 +: 16]  = a;
    b0.wdata[p*16 +: 16] = d;
  endtask

  function automatic int oh_idx(input logic [2:0] oh);
    return (oh == 3'b010) ? 1 : (oh == 3'b100) ? 2 : 0;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int got_acks;
    int en_at;
    int ack_at;
    logic [2:0]  e;
    logic [15:0] cyc_en;
    logic [15:0] got_rd;
    logic [2:0]  got_ack;

    b0.req = '0; b0.we = '0; b0.addr = '0; b0.wdata = '0;
    b2.req = '0; b2.we = '0; b2.addr = '0; b2.wdata = '0;
    b3.req = '0; b3.we = '0; b3.addr = '0; b3.wdata = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_grant", b0.grant, 3'b000);
    check("rst_ack", b0.ack, 3'b000);
    check("rst_busy", b0.busy, 1'b0);
    check("rst_mem_en", b0.mem_en, 1'b0);
    check("rst_mem_we", b0.mem_we, 1'b0);
    check("rst_mem_addr", b0.mem_addr, 16'h0000);
    check("rst_rdata", b0.rdata, 16'h0000);
    check("rst_state", st0, 2'd0);
    rst_n = 1'b1;
    tick();

    // single read, port 0
    set_port0(0, 1'b0, 16'h0010, 16'h0000);
    b0.req = 3'b001;
    base = en0_cnt;
    tick();
    check("rd_mem_en_c1", b0.mem_en, 1'b1);
    check("rd_mem_addr_c1", b0.mem_addr, 16'h0010);
    check("rd_grant_c1", b0.grant, 3'b001);
    check("rd_busy_c1", b0.busy, 1'b1);
    tick();
    check("rd_mem_en_c2", b0.mem_en, 1'b0);
    check("rd_ack_c2", b0.ack, 3'b000);
    tick();
    check("rd_ack_c3", b0.ack, 3'b001);
    check("rd_rdata_c3", b0.rdata, 16'h8005);
    b0.req = 3'b000;
    tick();
    check("rd_busy_c4", b0.busy, 1'b0);
    check("rd_grant_c4", b0.grant, 3'b000);
    check("rd_ack_c4", b0.ack, 3'b000);
    check("rd_en_count", en0_cnt - base, 1);

    // write by port 1, read back by port 2
    set_port0(1, 1'b1, 16'h0200, 16'hBEEF);
    b0.req = 3'b010;
    base = en0_cnt;
    tick();
    check("wr_mem_en", b0.mem_en, 1'b1);
    check("wr_mem_we", b0.mem_we, 1'b1);
    check("wr_mem_wdata", b0.mem_wdata, 16'hBEEF);
    check("wr_grant", b0.grant, 3'b010);
    tick();
    check("wr_ack_c2", b0.ack, 3'b010);
    check("wr_mem_we_ack", b0.mem_we, 1'b0);
    check("wr_rdata_kept", b0.rdata, 16'h8005);
    b0.req = 3'b000;
    tick();
    set_port0(2, 1'b0, 16'h0200, 16'h0000);
    b0.req = 3'b100;
    tick();
    check("rb_mem_en", b0.mem_en, 1'b1);
    check("rb_mem_we", b0.mem_we, 1'b0);
    check("rb_mem_addr", b0.mem_addr, 16'h0200);
    tick();
    tick();
    check("rb_ack", b0.ack, 3'b100);
    check("rb_rdata", b0.rdata, 16'hBEEF);
    b0.req = 3'b000;
    tick();
    check("wr_rb_en_count", en0_cnt - base, 2);

    // request withdrawn during ISSUE
    set_port0(1, 1'b0, 16'h0040, 16'h0000);
    b0.req = 3'b010;
    base = en0_cnt;
    tick();
    check("wd_mem_en", b0.mem_en, 1'b1);
    b0.req = 3'b000;
    tick();
    tick();
    check("wd_ack", b0.ack, 3'b010);
    check("wd_rdata", b0.rdata, 16'h1234);
    repeat (3) tick();
    check("wd_busy", b0.busy, 1'b0);
    check("wd_en_count", en0_cnt - base, 1);

    // simultaneous requests from reset release
    set_port0(0, 1'b0, 16'h0030, 16'h0000);
    set_port0(1, 1'b0, 16'h0031, 16'h0000);
    set_port0(2, 1'b0, 16'h0032, 16'h0000);
    rst_n = 1'b0;
    b0.req = 3'b111;
    tick();
    tick();
    rst_n = 1'b1;
`ifdef MEMARB_ROUND_ROBIN_EN
    exp_q.push_back(3'b001); exp_q.push_back(3'b010);
    exp_q.push_back(3'b100); exp_q.push_back(3'b001);
`else
    exp_q.push_back(3'b001); exp_q.push_back(3'b001);
    exp_q.push_back(3'b001); exp_q.push_back(3'b001);
`endif
    got_acks = 0;
    for (int i = 0; i < 40 && got_acks < 4; i++) begin
      tick();
      if (b0.ack != 3'b000) begin
        e = exp_q.pop_front();
        check("arb_ack", b0.ack, e);
        check("arb_rdata", b0.rdata, (16'h0030 + 16'(oh_idx(e))) ^ 16'h5A5A);
        got_acks++;
        if (got_acks == 4) b0.req = 3'b000;
      end
    end
    check("arb_ack_count", got_acks, 4);
    tick();
    tick();
    check("arb_idle", b0.busy, 1'b0);

    // reset during WAIT on the READ_LAT=3 instance
    b3.we[0] = 1'b0;
    b3.addr[15:0] = 16'h0050;
    b3.req = 3'b001;
    tick();
    check("rs_mem_en", b3.mem_en, 1'b1);
    tick();
    check("rs_in_wait", st3, 2'd2);
    rst_n = 1'b0;
    tick();
    check("rs_ack", b3.ack, 3'b000);
    check("rs_grant", b3.grant, 3'b000);
    check("rs_busy", b3.busy, 1'b0);
    check("rs_mem_en0", b3.mem_en, 1'b0);
    check("rs_mem_we", b3.mem_we, 1'b0);
    check("rs_mem_addr", b3.mem_addr, 16'h0000);
    check("rs_mem_wdata", b3.mem_wdata, 16'h0000);
    check("rs_rdata", b3.rdata, 16'h0000);
    check("rs_state", st3, 2'd0);
    check("rs_no_ack", ack3_cnt, 0);
    rst_n = 1'b1;
    en_at = -1; ack_at = -1; cyc_en = '0; got_rd = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (b3.mem_en && en_at < 0) begin
        en_at  = i;
        cyc_en = cyc;
      end
      if (b3.ack != 3'b000 && ack_at < 0) begin
        ack_at = i;
        got_rd = b3.rdata;
        b3.req = 3'b000;
      end
    end
    check("rl3_en_cycle", en_at, 1);
    check("rl3_ack_cycle", ack_at, 5);
    check("rl3_rdata", got_rd, (cyc_en + 16'd3) ^ 16'hA5A5);
    check("rl3_ack_total", ack3_cnt, 1);

    // read latency on the READ_LAT=2 instance, port 2
    b2.we[2] = 1'b0;
    b2.addr[47:32] = 16'h0060;
    b2.req = 3'b100;
    en_at = -1; ack_at = -1; cyc_en = '0; got_rd = '0; got_ack = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (b2.mem_en && en_at < 0) begin
        en_at  = i;
        cyc_en = cyc;
      end
      if (b2.ack != 3'b000 && ack_at < 0) begin
        ack_at  = i;
        got_rd  = b2.rdata;
        got_ack = b2.ack;
        b2.req  = 3'b000;
      end
    end
    check("rl2_en_cycle", en_at, 1);
    check("rl2_ack_cycle", ack_at, 4);
    check("rl2_ack", got_ack, 3'b100);
    check("rl2_rdata", got_rd, (cyc_en + 16'd2) ^ 16'hA5A5);
    check("rl2_idle", b2.busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
